// File: rtl/rcvfifo_pkg.sv
// Shared constants for the packing receive FIFO: Wishbone address map,
// status word layout and the value returned when reading an empty FIFO.
package rcvfifo_pkg;

    localparam logic ADR_DATA = 1'b0;
    localparam logic ADR_STAT = 1'b1;

    // Status word, LSB upward: fifocnt[MBITS:0], almost_full, empty, overflow.
    localparam int STAT_CNT_LSB = 0;

    function automatic int stat_afull_bit(input int mbits);
        return mbits + 1;
    endfunction

    function automatic int stat_empty_bit(input int mbits);
        return mbits + 2;
    endfunction

    function automatic int stat_ovf_bit(input int mbits);
        return mbits + 3;
    endfunction

    localparam logic [255:0] EMPTY_DATA = '1;

endpackage

// File: rtl/rcvfifo_packer.sv
// Lane packer: gathers PACK input lanes into one word, pads a block tail
// with FILL and strobes commit / block-end to the FIFO core.
module rcvfifo_packer #(
    parameter int             DW   = 16,
    parameter int             PACK = 2,
    parameter logic [DW-1:0]  FILL = '1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [DW-1:0]        din,
    input  logic                 din_vld,
    output logic                 commit,
    output logic [DW*PACK-1:0]   word,
    output logic                 blk_end
);

    localparam int LNW = (PACK > 1) ? $clog2(PACK) : 1;

    logic [LNW-1:0]             ln_q, ln_d;
    logic                       seen_q, seen_d;
    logic [PACK-1:0][DW-1:0]    lanes_q, lanes_d;

    always_comb begin
        ln_d    = ln_q;
        seen_d  = seen_q;
        lanes_d = lanes_q;
        commit  = 1'b0;
        blk_end = 1'b0;
        word    = '0;

        // Lanes below ln are held, lane ln takes din, the rest pad.
        for (int i = 0; i < PACK; i++) begin
            if (i < int'(ln_q)) begin
                word[i*DW +: DW] = lanes_q[i];
            end else if (i == int'(ln_q) && din_vld) begin
                word[i*DW +: DW] = din;
            end else begin
                word[i*DW +: DW] = FILL;
            end
        end

        if (clr) begin
            ln_d   = '0;
            seen_d = 1'b0;
        end else if (din_vld) begin
            seen_d        = 1'b1;
            lanes_d[ln_q] = din;
            if (int'(ln_q) == PACK - 1) begin
                commit = 1'b1;
                ln_d   = '0;
            end else begin
                ln_d = ln_q + LNW'(1);
            end
        end else begin
            commit  = (ln_q != '0);
            blk_end = seen_q;
            seen_d  = 1'b0;
            ln_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ln_q    <= '0;
            seen_q  <= 1'b0;
            lanes_q <= '0;
        end else begin
            ln_q    <= ln_d;
            seen_q  <= seen_d;
            lanes_q <= lanes_d;
        end
    end

endmodule

// File: rtl/rcvfifo_pack.sv
// Receive FIFO top: word RAM, pointers, fill count, overflow flag and the
// Wishbone slave that pops data, reports status and clears on any write.
module rcvfifo_pack
    import rcvfifo_pkg::*;
#(
    parameter int             DW    = 16,
    parameter int             PACK  = 2,
    parameter int             MBITS = 13,
    parameter logic [DW-1:0]  FILL  = 16'hFFFF,
    parameter int             AFULL = 2**13 - 64
) (
    input  logic                  wb_clk,
    input  logic                  reset,
    input  logic [DW-1:0]         din,
    input  logic                  din_vld,
    input  logic                  wb_cyc,
    input  logic                  wb_stb,
    input  logic                  wb_we,
    input  logic                  wb_adr,
    output logic                  wb_ack,
    output logic [DW*PACK-1:0]    wb_dat_o,
    output logic [MBITS:0]        fifocnt,
    output logic [15:0]           blkcnt,
    output logic                  almost_full,
    output logic                  overflow
);

    localparam int WW      = DW * PACK;
    localparam int DEPTH   = 2**MBITS;
    localparam int AF_BIT  = stat_afull_bit(MBITS);
    localparam int EMP_BIT = stat_empty_bit(MBITS);
    localparam int OVF_BIT = stat_ovf_bit(MBITS);

    logic [WW-1:0]     mem [DEPTH];

    logic [MBITS-1:0]  waddr_q, waddr_d;
    logic [MBITS-1:0]  raddr_q, raddr_d;
    logic [MBITS:0]    count_q, count_d;
    logic [15:0]       blkcnt_q, blkcnt_d;
    logic              ovf_q, ovf_d;
    logic              ack_q, ack_d;
    logic [WW-1:0]     dat_q, dat_d;

    logic              req, clr, pop, wr_en;
    logic              empty, full;
    logic              commit, blk_end;
    logic [WW-1:0]     word;
    logic [WW-1:0]     status;

    rcvfifo_packer #(
        .DW   (DW),
        .PACK (PACK),
        .FILL (FILL)
    ) u_packer (
        .clk     (wb_clk),
        .rst     (reset),
        .clr     (clr),
        .din     (din),
        .din_vld (din_vld),
        .commit  (commit),
        .word    (word),
        .blk_end (blk_end)
    );

    assign req   = wb_cyc & wb_stb & ~ack_q;
    assign clr   = req & wb_we;
    assign empty = (count_q == '0);
    assign full  = count_q[MBITS];
    // Full is judged on the registered count, so a same-cycle pop cannot make room.
    assign wr_en = commit & ~full;
    assign pop   = req & ~wb_we & (wb_adr == ADR_DATA) & ~empty;

    assign almost_full = int'(count_q) >= AFULL;

    always_comb begin
        status = '0;
        status[STAT_CNT_LSB +: MBITS+1] = count_q;
        status[AF_BIT]  = almost_full;
        status[EMP_BIT] = empty;
        status[OVF_BIT] = ovf_q;
    end

    always_comb begin
        waddr_d  = waddr_q;
        raddr_d  = raddr_q;
        count_d  = count_q;
        blkcnt_d = blkcnt_q;
        ovf_d    = ovf_q;
        ack_d    = req;
        dat_d    = dat_q;

        if (req && !wb_we) begin
            if (wb_adr == ADR_STAT) begin
                dat_d = status;
            end else if (empty) begin
                dat_d = EMPTY_DATA[WW-1:0];
            end else begin
                dat_d = mem[raddr_q];
            end
        end

        if (clr) begin
            waddr_d  = '0;
            raddr_d  = '0;
            count_d  = '0;
            blkcnt_d = '0;
            ovf_d    = 1'b0;
        end else begin
            waddr_d  = waddr_q + MBITS'(wr_en);
            raddr_d  = raddr_q + MBITS'(pop);
            count_d  = count_q + (MBITS+1)'(wr_en) - (MBITS+1)'(pop);
            blkcnt_d = blkcnt_q + 16'(blk_end);
            ovf_d    = ovf_q | (commit & full);
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wr_en) begin
            mem[waddr_q] <= word;
        end
    end

    always_ff @(posedge wb_clk or posedge reset) begin
        if (reset) begin
            waddr_q  <= '0;
            raddr_q  <= '0;
            count_q  <= '0;
            blkcnt_q <= '0;
            ovf_q    <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            waddr_q  <= waddr_d;
            raddr_q  <= raddr_d;
            count_q  <= count_d;
            blkcnt_q <= blkcnt_d;
            ovf_q    <= ovf_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
        end
    end

    assign wb_ack   = ack_q;
    assign wb_dat_o = dat_q;
    assign fifocnt  = count_q;
    assign blkcnt   = blkcnt_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_rcvfifo_pack.sv
// Bench for rcvfifo_pack: directed scenarios plus random traffic against
// a queue-based reference of the packing FIFO.
module tb_rcvfifo_pack;

    localparam int P     = 2;
    localparam int DEPTH = 8;
    localparam int AF    = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] din = '0;
    logic        din_vld = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic        wb_adr = 1'b0;
    logic        wb_ack;
    logic [31:0] wb_dat_o;
    logic [3:0]  fifocnt;
    logic [15:0] blkcnt;
    logic        almost_full;
    logic        overflow;

    logic [15:0] din4 = '0;
    logic        vld4 = 1'b0;
    logic        cyc4 = 1'b0;
    logic        we4 = 1'b0;
    logic        adr4 = 1'b0;
    logic        ack4;
    logic [63:0] dat4;
    logic [3:0]  cnt4;
    logic [15:0] blk4;
    logic        af4;
    logic        ovf4;

    int total = 0;
    int bad = 0;

    logic [31:0] q[$];
    logic [15:0] part[$];
    bit          seen;
    bit          m_ovf;
    bit          m_ack;
    int          m_blk;
    logic [31:0] exp_dat;

    always #5 clk = ~clk;

    rcvfifo_pack #(
        .DW(16), .PACK(2), .MBITS(3), .FILL(16'hFFFF), .AFULL(AF)
    ) dut (
        .wb_clk(clk), .reset(reset), .din(din), .din_vld(din_vld),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_adr(wb_adr), .wb_ack(wb_ack), .wb_dat_o(wb_dat_o),
        .fifocnt(fifocnt), .blkcnt(blkcnt),
        .almost_full(almost_full), .overflow(overflow)
    );

    rcvfifo_pack #(
        .DW(16), .PACK(4), .MBITS(3), .FILL(16'hFFFF), .AFULL(AF)
    ) dut4 (
        .wb_clk(clk), .reset(reset), .din(din4), .din_vld(vld4),
        .wb_cyc(cyc4), .wb_stb(cyc4), .wb_we(we4),
        .wb_adr(adr4), .wb_ack(ack4), .wb_dat_o(dat4),
        .fifocnt(cnt4), .blkcnt(blk4),
        .almost_full(af4), .overflow(ovf4)
    );

    task automatic m_reset();
        q.delete();
        part.delete();
        seen  = 0;
        m_ovf = 0;
        m_ack = 0;
        m_blk = 0;
    endtask

    task automatic m_commit(input int pre);
        logic [31:0] w;
        for (int i = 0; i < P; i++) begin
            w[i*16 +: 16] = (i < part.size()) ? part[i] : 16'hFFFF;
        end
        part.delete();
        if (pre < DEPTH) q.push_back(w);
        else m_ovf = 1;
    endtask

    // Drive one clock of stimulus and advance the reference to match.
    task automatic step(input logic vld, input logic [15:0] d,
                        input logic rq, input logic we, input logic adr);
        int pre;
        bit acc;
        bit clr;
        bit pop;
        din = d;
        din_vld = vld;
        wb_cyc = rq;
        wb_stb = rq;
        wb_we = we;
        wb_adr = adr;
        pre = q.size();
        acc = rq && !m_ack;
        clr = acc && we;
        pop = acc && !we && !adr && pre > 0;
        if (acc && !we) begin
            if (adr)
                exp_dat = {25'b0, m_ovf, pre == 0, pre >= AF, 4'(pre)};
            else
                exp_dat = (pre > 0) ? q[0] : 32'hFFFF_FFFF;
        end
        if (!clr) begin
            if (vld) begin
                part.push_back(d);
                seen = 1;
                if (part.size() == P) m_commit(pre);
            end else begin
                if (part.size() > 0) m_commit(pre);
                if (seen) m_blk++;
                seen = 0;
            end
        end
        if (pop) void'(q.pop_front());
        if (clr) begin
            q.delete();
            part.delete();
            seen = 0;
            m_blk = 0;
            m_ovf = 0;
        end
        m_ack = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (wb_ack !== 1'b0) begin
            bad++; $display("FAIL rst_ack got=%0h want=0", wb_ack);
        end
        total++;
        if (wb_dat_o !== 32'h0) begin
            bad++; $display("FAIL rst_dat got=%0h want=0", wb_dat_o);
        end
        total++;
        if (fifocnt !== 4'h0) begin
            bad++; $display("FAIL rst_cnt got=%0h want=0", fifocnt);
        end
        total++;
        if (blkcnt !== 16'h0) begin
            bad++; $display("FAIL rst_blk got=%0h want=0", blkcnt);
        end
        total++;
        if ({almost_full, overflow} !== 2'b00) begin
            bad++;
            $display("FAIL rst_flags got=%b%b want=00", almost_full, overflow);
        end
        reset = 1'b0;
        m_reset();
        idle();
    endtask

    task automatic test_pack2();
        step(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h3333, 1'b0, 1'b0, 1'b0);
        idle();
        total++;
        if (fifocnt !== 4'd2) begin
            bad++; $display("FAIL p2_cnt got=%0d want=2", fifocnt);
        end
        total++;
        if (blkcnt !== 16'd1) begin
            bad++; $display("FAIL p2_blk got=%0d want=1", blkcnt);
        end
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        total++;
        if (wb_ack !== 1'b1 || wb_dat_o !== 32'h2222_1111) begin
            bad++;
            $display("FAIL p2_w0 got=%b/%h want=1/22221111", wb_ack, wb_dat_o);
        end
        idle();
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        total++;
        if (wb_dat_o !== 32'hFFFF_3333) begin
            bad++; $display("FAIL p2_w1 got=%h want=ffff3333", wb_dat_o);
        end
        idle();
    endtask

    task automatic test_pack4();
        idle();
        for (int i = 1; i <= 5; i++) begin
            din4 = 16'(i);
            vld4 = 1'b1;
            @(posedge clk);
            #1;
        end
        vld4 = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (cnt4 !== 4'd2 || blk4 !== 16'd1) begin
            bad++;
            $display("FAIL p4_cnt got=%0d/%0d want=2/1", cnt4, blk4);
        end
        cyc4 = 1'b1;
        @(posedge clk);
        #1;
        cyc4 = 1'b0;
        total++;
        if (ack4 !== 1'b1 || dat4 !== 64'h0004_0003_0002_0001) begin
            bad++; $display("FAIL p4_w0 got=%b/%h", ack4, dat4);
        end
        @(posedge clk);
        #1;
        cyc4 = 1'b1;
        @(posedge clk);
        #1;
        cyc4 = 1'b0;
        total++;
        if (dat4 !== 64'hFFFF_FFFF_FFFF_0005) begin
            bad++; $display("FAIL p4_w1 got=%h want=ffffffffffff0005", dat4);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow();
        step(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
        idle();
        for (int i = 1; i <= 18; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        idle();
        total++;
        if (fifocnt !== 4'd8 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_state got=%0d/%b want=8/1", fifocnt, overflow);
        end
        total++;
        if (almost_full !== 1'b1) begin
            bad++; $display("FAIL ovf_af got=%b want=1", almost_full);
        end
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        total++;
        if (wb_dat_o !== exp_dat || exp_dat !== 32'h58) begin
            bad++;
            $display("FAIL ovf_stat got=%h want=%h", wb_dat_o, exp_dat);
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
            total++;
            if (wb_dat_o !== exp_dat) begin
                bad++;
                $display("FAIL ovf_pop%0d got=%h want=%h", i, wb_dat_o, exp_dat);
            end
            idle();
        end
        total++;
        if (exp_dat !== 32'h0010_000F) begin
            bad++; $display("FAIL ovf_last got=%h want=0010000f", exp_dat);
        end
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        total++;
        if (wb_dat_o !== 32'hFFFF_FFFF || fifocnt !== 4'd0) begin
            bad++;
            $display("FAIL ovf_empty got=%h/%0d want=ffffffff/0", wb_dat_o, fifocnt);
        end
        idle();
        step(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b0);
        idle();
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        total++;
        if (wb_dat_o !== 32'hBBBB_AAAA) begin
            bad++; $display("FAIL ovf_after got=%h want=bbbbaaaa", wb_dat_o);
        end
        idle();
    endtask

    task automatic test_same_cycle();
        step(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
        idle();
        for (int i = 1; i <= 11; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        total++;
        if (fifocnt !== 4'd5) begin
            bad++; $display("FAIL sc_pre got=%0d want=5", fifocnt);
        end
        step(1'b1, 16'd12, 1'b1, 1'b0, 1'b0);
        total++;
        if (fifocnt !== 4'd5 || wb_dat_o !== 32'h0002_0001) begin
            bad++;
            $display("FAIL sc_mid got=%0d/%h want=5/00020001", fifocnt, wb_dat_o);
        end
        idle();
        for (int i = 13; i <= 19; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'd20, 1'b1, 1'b0, 1'b0);
        total++;
        if (fifocnt !== 4'd7 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL sc_full got=%0d/%b want=7/1", fifocnt, overflow);
        end
        idle();
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
            total++;
            if (wb_dat_o !== exp_dat) begin
                bad++;
                $display("FAIL sc_pop%0d got=%h want=%h", i, wb_dat_o, exp_dat);
            end
            idle();
        end
    endtask

    task automatic test_clear_mid();
        step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h5555, 1'b1, 1'b1, 1'b0);
        idle();
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        total++;
        if (wb_dat_o !== exp_dat || exp_dat !== 32'h20) begin
            bad++;
            $display("FAIL clr_stat got=%h want=%h", wb_dat_o, exp_dat);
        end
        total++;
        if (fifocnt !== 4'd0 || blkcnt !== 16'd0) begin
            bad++;
            $display("FAIL clr_cnt got=%0d/%0d want=0/0", fifocnt, blkcnt);
        end
        idle();
        step(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b0);
        idle();
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        total++;
        if (wb_dat_o !== 32'hBBBB_AAAA) begin
            bad++; $display("FAIL clr_lane0 got=%h want=bbbbaaaa", wb_dat_o);
        end
        idle();
    endtask

    task automatic test_wrap();
        int guard;
        step(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
        idle();
        for (int k = 0; k < DEPTH + 3; k++) begin
            step(1'b1, 16'(16'h100 + k), 1'b0, 1'b0, 1'b0);
            step(1'b1, 16'(16'h200 + k), k[0], 1'b0, 1'b0);
            if (k[0]) begin
                total++;
                if (wb_dat_o !== exp_dat) begin
                    bad++;
                    $display("FAIL wrap_rd%0d got=%h want=%h", k, wb_dat_o, exp_dat);
                end
            end
        end
        idle();
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
            total++;
            if (wb_dat_o !== exp_dat) begin
                bad++;
                $display("FAIL wrap_drain got=%h want=%h", wb_dat_o, exp_dat);
            end
            idle();
            guard++;
        end
        total++;
        if (fifocnt !== 4'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL wrap_end got=%0d/%b want=0/0", fifocnt, overflow);
        end
    endtask

    task automatic test_random();
        logic       vld;
        logic       rq;
        logic       we;
        logic       adr;
        for (int c = 0; c < 600; c++) begin
            if (c < 300) begin
                vld = ($urandom_range(0, 3) != 0);
                rq  = ($urandom_range(0, 5) == 0);
            end else begin
                vld = ($urandom_range(0, 3) == 0);
                rq  = ($urandom_range(0, 1) == 0);
            end
            we  = ($urandom_range(0, 60) == 0);
            adr = ($urandom_range(0, 4) == 0);
            step(vld, 16'($urandom), rq, we, adr);
            total++;
            if (wb_ack !== m_ack) begin
                bad++; $display("FAIL rnd_ack c=%0d got=%b want=%b", c, wb_ack, m_ack);
            end
            if (m_ack && !we) begin
                total++;
                if (wb_dat_o !== exp_dat) begin
                    bad++;
                    $display("FAIL rnd_dat c=%0d got=%h want=%h", c, wb_dat_o, exp_dat);
                end
            end
            total++;
            if (fifocnt !== 4'(q.size()) || blkcnt !== 16'(m_blk)) begin
                bad++;
                $display("FAIL rnd_cnt c=%0d got=%0d/%0d want=%0d/%0d",
                         c, fifocnt, blkcnt, q.size(), m_blk);
            end
            total++;
            if (overflow !== m_ovf || almost_full !== (q.size() >= AF)) begin
                bad++;
                $display("FAIL rnd_flag c=%0d got=%b%b want=%b%b",
                         c, overflow, almost_full, m_ovf, q.size() >= AF);
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 17; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        idle();
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        total++;
        if (wb_ack !== 1'b1) begin
            bad++; $display("FAIL ar_pre got=%b want=1", wb_ack);
        end
        #2;
        reset = 1'b1;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        #1;
        total++;
        if (wb_ack !== 1'b0 || wb_dat_o !== 32'h0) begin
            bad++;
            $display("FAIL ar_wb got=%b/%h want=0/0", wb_ack, wb_dat_o);
        end
        total++;
        if (fifocnt !== 4'd0 || blkcnt !== 16'd0) begin
            bad++;
            $display("FAIL ar_cnt got=%0d/%0d want=0/0", fifocnt, blkcnt);
        end
        total++;
        if ({almost_full, overflow} !== 2'b00) begin
            bad++;
            $display("FAIL ar_flags got=%b%b want=00", almost_full, overflow);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
        idle();
    endtask

    initial begin
        test_reset();
        test_pack2();
        test_pack4();
        test_overflow();
        test_same_cycle();
        test_clear_mid();
        test_wrap();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
